uart_frame_tx: RTL and testbench

- UART framed-sample transmitter: the FPGA-to-host direction of the header-plus-sample link.
- Accepts 8-bit processed samples over a valid/ready handshake and buffers them in a small FIFO.
- For each sample it emits a two-byte frame on uart_tx: HEADER_BYTE, then the sample. Format is 8N1, LSB first.
- Sits between the sample filter datapath and the board UART TX pin. The host re-syncs on HEADER_BYTE.

---
 rtl/uart_frame_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
`timescale 1ns/1ps
// Framed-sample UART transmitter: buffers 8-bit samples in a small FIFO and
// sends each one as a HEADER_BYTE + sample pair, 8N1, LSB first.
module uart_frame_tx #(
  parameter int          CLK_FREQ     = 50_000_000,
  parameter int          BAUD_RATE    = 115200,
  parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter logic [7:0]  HEADER_BYTE  = 8'hAA,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk_50mhz,
  input  logic        reset,
  input  logic [7:0]  sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Handshake: a sample transfers on every rising edge where sample_valid and
  // sample_ready are both high; sample_ready is a flop equal to FIFO not-full,
  // and sample_data is captured on that edge so it need not be held afterwards.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_next;
  logic [2:0]    bit_idx;
  logic [2:0]    idx_next;
  logic [7:0]    shifter;
  logic [7:0]    shifter_next;
  logic [7:0]    payload;
  logic [7:0]    payload_next;
  logic          phase_payload;
  logic          phase_next;
  logic [15:0]   frames_next;
  logic          tx_next;
  logic          bit_done;

  assign push       = sample_valid && sample_ready;
  assign fifo_empty = (fifo_count == '0);
  assign bit_done   = (baud_cnt == BIT_LAST);
  assign busy       = (state != IDLE) || !fifo_empty;

  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      sample_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count   <= count_next;
      sample_ready <= (count_next != FIFO_FULL);
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (push) fifo_mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shifter       <= '0;
      payload       <= '0;
      phase_payload <= 1'b0;
      frames_sent   <= '0;
      uart_tx       <= 1'b1;
    end else begin
      state         <= state_next;
      baud_cnt      <= baud_next;
      bit_idx       <= idx_next;
      shifter       <= shifter_next;
      payload       <= payload_next;
      phase_payload <= phase_next;
      frames_sent   <= frames_next;
      uart_tx       <= tx_next;
    end
  end

  // The line level is registered from the current state, so it trails the
  // state register by one cycle and every bit still lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt;
    idx_next     = bit_idx;
    shifter_next = shifter;
    payload_next = payload;
    phase_next   = phase_payload;
    frames_next  = frames_sent;
    pop          = 1'b0;
    tx_next      = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          payload_next = fifo_mem[rd_ptr];
          shifter_next = HEADER_BYTE;
          phase_next   = 1'b0;
          baud_next    = '0;
          state_next   = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_done) begin
          baud_next  = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_next = shifter[bit_idx];
        if (bit_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 idx_next   = bit_idx + 3'd1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_done) begin
          baud_next = '0;
          if (!phase_payload) begin
            shifter_next = payload;
            phase_next   = 1'b1;
            state_next   = START;
          end else begin
            frames_next = frames_sent + 16'd1;
            // Chain straight into the next header when more samples wait.
            if (!fifo_empty) begin
              pop          = 1'b1;
              payload_next = fifo_mem[rd_ptr];
              shifter_next = HEADER_BYTE;
              phase_next   = 1'b0;
              state_next   = START;
            end else begin
              state_next = IDLE;
            end
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
`timescale 1ns/1ps
// Bench for uart_frame_tx: a cycle-level frame schedule model checked every
// cycle, a bit-centre line decoder, and hand-computed directed checks.
module tb_uart_frame_tx;

  localparam int         CPB   = 434;
  localparam int         FRAME = 20 * CPB;
  localparam int         DEPTH = 4;
  localparam logic [7:0] HDR   = 8'hAA;

  logic        clk_50mhz = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sample_data = 8'h00;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        uart_tx;
  logic        busy;
  logic [15:0] frames_sent;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  uart_frame_tx dut (
    .clk_50mhz    (clk_50mhz),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .frames_sent  (frames_sent)
  );

  // clock/reset block
  always #10 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) cyc++;

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: samples wait in a queue; a frame occupies the line for FRAME cycles
  // starting one cycle after the pop, and pops happen whenever the line is free.
  logic [7:0]  mq[$];
  bit          active = 1'b0;
  int unsigned mcyc = 0;
  int unsigned cur_pop = 0;
  logic [7:0]  cur_pl = 8'h00;
  logic [15:0] frames_m = 16'h0000;
  bit          ready_m = 1'b0;
  logic        tx_m = 1'b1;
  logic        busy_m = 1'b0;
  bit          push_m;
  logic [7:0]  data_m;

  function automatic logic frame_bit(input logic [7:0] pl, input int j);
    logic [7:0] b;
    int pos;
    b   = (j < 10) ? HDR : pl;
    pos = j % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  always @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      mq.delete();
      active   = 1'b0;
      frames_m = 16'h0000;
      ready_m  = 1'b0;
      tx_m     = 1'b1;
      busy_m   = 1'b0;
    end else begin
      mcyc++;
      push_m = sample_valid && ready_m;
      data_m = sample_data;
      if (active && mcyc == cur_pop + FRAME) begin
        frames_m = frames_m + 16'd1;
        active   = 1'b0;
      end
      if (!active && mq.size() > 0) begin
        cur_pl  = mq.pop_front();
        cur_pop = mcyc;
        active  = 1'b1;
      end
      if (push_m) mq.push_back(data_m);
      ready_m = (mq.size() < DEPTH);
      if (active && mcyc > cur_pop)
        tx_m = frame_bit(cur_pl, int'((mcyc - cur_pop - 1) / CPB));
      else
        tx_m = 1'b1;
      busy_m = active || (mq.size() > 0);
    end
  end

  // scoreboard: per-cycle compare against the model
  bit cmp_en = 1'b0;
  always @(negedge clk_50mhz) begin
    if (cmp_en && !reset) begin
      check("uart_tx", uart_tx, tx_m);
      check("sample_ready", sample_ready, ready_m);
      check("busy", busy, busy_m);
      check("frames_sent", frames_sent, frames_m);
    end
  end

  // Line decoder sampling at bit centres; decoded bytes go to the expected queue compare.
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  bit         dec_on = 1'b0;
  int         dec_cnt = 0;
  int         dec_k = 0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge clk_50mhz or posedge reset) begin
    if (reset) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (uart_tx === 1'b0) begin
        dec_on  = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == CPB / 2) begin
        check("start_bit", uart_tx, 1'b0);
      end else if (dec_cnt > CPB / 2 && (dec_cnt - CPB / 2) % CPB == 0) begin
        dec_k = (dec_cnt - CPB / 2) / CPB;
        if (dec_k <= 8) begin
          dec_byte[dec_k-1] = uart_tx;
        end else begin
          check("stop_bit", uart_tx, 1'b1);
          dec_q.push_back(dec_byte);
          dec_on = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] b, output int acc_cyc);
    int guard;
    bit r;
    guard = 0;
    sample_valid = 1'b1;
    sample_data  = b;
    do begin
      r = sample_ready;
      @(negedge clk_50mhz);
      guard++;
    end while (!r && guard < 20000);
    acc_cyc = cyc;
    check("accepted", r, 1'b1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge clk_50mhz);
      guard++;
    end while ((busy || !uart_tx) && guard < 60000);
    check("idle_reached", busy, 1'b0);
    repeat (3) @(negedge clk_50mhz);
  endtask

  int a[7];
  int a0;

  initial begin
    exp_q = '{8'hAA, 8'hFA, 8'hAA, 8'h01, 8'hAA, 8'h02, 8'hAA, 8'h03, 8'hAA, 8'h04,
              8'hAA, 8'h05, 8'hAA, 8'h06, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h55};

    // reset state
    repeat (3) @(negedge clk_50mhz);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_ready", sample_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frames", frames_sent, 16'h0000);
    reset  = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk_50mhz);
    check("ready_after_reset", sample_ready, 1'b1);
    repeat (4) @(negedge clk_50mhz);

    // single sample: line falls at the second edge after acceptance
    send(8'hFA, a0);
    sample_valid = 1'b0;
    @(negedge clk_50mhz);
    check("tx_high_acc_plus1", uart_tx, 1'b1);
    @(negedge clk_50mhz);
    check("tx_low_acc_plus2", uart_tx, 1'b0);
    wait_idle();
    check("single_frames", frames_sent, 16'd1);
    check("single_busy", busy, 1'b0);
    check("single_tx_idle", uart_tx, 1'b1);

    // burst of six with valid held; FIFO fills and sample 6 waits for frame 2's pop
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), a[i]);
      if (i == 5) check("ready_low_after_5th", sample_ready, 1'b0);
    end
    sample_valid = 1'b0;
    for (int i = 2; i <= 5; i++) check("burst_consecutive", a[i] - a[1], i - 1);
    check("burst_6th_at_ready_rise", a[6] - a[1], FRAME + 2);
    wait_idle();
    check("burst_frames", frames_sent, 16'd7);

    // payload equal to the header byte goes out unchanged
    send(8'hAA, a0);
    sample_valid = 1'b0;
    wait_idle();
    check("hdr_payload_frames", frames_sent, 16'd8);

    // reset during payload data bit 3 (0x33 has bit 3 low), one sample still queued
    send(8'h33, a0);
    send(8'h99, a0);
    sample_valid = 1'b0;
    repeat (14 * CPB + 200) @(negedge clk_50mhz);
    check("pre_reset_tx_bit3", uart_tx, 1'b0);
    check("pre_reset_busy", busy, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("reset_tx_now", uart_tx, 1'b1);
    check("reset_ready_now", sample_ready, 1'b0);
    check("reset_busy_now", busy, 1'b0);
    check("reset_frames_now", frames_sent, 16'h0000);
    repeat (3) @(negedge clk_50mhz);
    reset = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    check("fifo_empty_after_reset", busy, 1'b0);
    check("tx_idle_after_reset", uart_tx, 1'b1);

    // counter wrap, combined with the clean post-reset 0x55 frame
    force dut.frames_sent = 16'hFFFF;
    frames_m = 16'hFFFF;
    repeat (2) @(negedge clk_50mhz);
    release dut.frames_sent;
    @(negedge clk_50mhz);
    check("preload_frames", frames_sent, 16'hFFFF);
    send(8'h55, a0);
    sample_valid = 1'b0;
    wait_idle();
    check("frames_wrap", frames_sent, 16'h0000);

    // decoded line contents
    check("decoded_count", dec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < dec_q.size()) check("decoded_byte", dec_q[i], exp_q[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
